// File: rtl/parity_arbiter.sv
// Round-robin arbiter that streams nibble frames from NREQ clients through one
// shared 4-input XOR unit and returns one parity/count/id/error result per frame.

module xor_four_input (
    input  logic [3:0] a,
    output logic       y
);
    assign y = ^a;
endmodule

module parity_arbiter #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [4*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_parity,
    output logic [CNT_W-1:0]        res_count,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic                    res_err
);
    localparam int ID_W = $clog2(NREQ);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      grant, rr_ptr, pick, cand;
    logic                 pick_vld;
    logic                 acc, acc_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic [TO_W-1:0]      idle_cnt;
    logic [NREQ-1:0][3:0] data_arr;
    logic [3:0]           xor_in;
    logic                 xor_out;
    logic                 beat, last_beat, timeout;
    int                   idx;

    assign data_arr = req_data;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx  = (int'(rr_ptr) + k) % NREQ;
            cand = ID_W'(idx);
            if (req_valid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // The only parity datapath: input muxed from the granted requester.
    assign xor_in = data_arr[grant];

    xor_four_input u_xor (
        .a (xor_in),
        .y (xor_out)
    );

    assign beat      = (state == BUSY) && req_valid[grant];
    assign last_beat = beat && req_last[grant];
    assign timeout   = (state == BUSY) && !beat && (idle_cnt == TO_W'(TIMEOUT - 1));
    assign acc_nxt   = acc ^ xor_out;
    assign count_nxt = (&count) ? count : count + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = BUSY;
            BUSY:    if (last_beat || timeout) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == BUSY) req_ready[grant] = 1'b1;
        res_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant      <= '0;
            rr_ptr     <= '0;
            acc        <= 1'b0;
            count      <= '0;
            idle_cnt   <= '0;
            res_parity <= 1'b0;
            res_count  <= '0;
            res_id     <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant    <= pick;
                        acc      <= 1'b0;
                        count    <= '0;
                        idle_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        acc      <= acc_nxt;
                        count    <= count_nxt;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    // Result is captured on the way into DONE and held until handshake.
                    if (last_beat) begin
                        res_parity <= acc_nxt;
                        res_count  <= count_nxt;
                        res_id     <= grant;
                        res_err    <= 1'b0;
                    end else if (timeout) begin
                        res_parity <= acc;
                        res_count  <= count;
                        res_id     <= grant;
                        res_err    <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready)
                        rr_ptr <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter; a second instance with CNT_W=2 shares the
// stimulus so counter saturation can be observed alongside the main instance.

module tb_parity_arbiter;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_last;
    logic [4*NREQ-1:0] req_data;
    logic              res_ready;

    logic [NREQ-1:0]   req_ready, req_ready_s;
    logic              res_valid, res_parity, res_err;
    logic [7:0]        res_count;
    logic [1:0]        res_id;
    logic              res_valid_s, res_parity_s, res_err_s;
    logic [1:0]        res_count_s;
    logic [1:0]        res_id_s;

    int checks = 0;
    int errors = 0;

    logic [15:0] ptab = 16'h6996;
    logic [1:0]  exp_order [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    int          beatn [NREQ];
    int          frames, onehot_bad;
    logic [NREQ-1:0] rdy, vld;
    logic [16:0] snap;

    parity_arbiter #(.NREQ(NREQ), .CNT_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
        .res_ready(res_ready), .res_parity(res_parity), .res_count(res_count),
        .res_id(res_id), .res_err(res_err)
    );

    parity_arbiter #(.NREQ(NREQ), .CNT_W(2), .TIMEOUT(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready_s), .res_valid(res_valid_s),
        .res_ready(res_ready), .res_parity(res_parity_s), .res_count(res_count_s),
        .res_id(res_id_s), .res_err(res_err_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] d, input logic l);
        req_valid[i]       = 1'b1;
        req_data[4*i +: 4] = d;
        req_last[i]        = l;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b0;
        tick(); tick();
        check("rst_ready",  req_ready,  0);
        check("rst_valid",  res_valid,  0);
        check("rst_parity", res_parity, 0);
        check("rst_count",  res_count,  0);
        check("rst_id",     res_id,     0);
        check("rst_err",    res_err,    0);
        rst_n = 1'b1;

        // Single frame 0x1, 0x3, 0x7 from requester 0
        set_req(0, 4'h1, 1'b0);
        #1 check("sf_idle_bubble", req_ready, 4'b0000);
        tick();
        check("sf_grant", req_ready, 4'b0001);
        tick(); set_req(0, 4'h3, 1'b0);
        tick(); set_req(0, 4'h7, 1'b1);
        tick(); clr_req(0);
        check("sf_valid",  res_valid,  1);
        check("sf_parity", res_parity, 0);
        check("sf_count",  res_count,  3);
        check("sf_id",     res_id,     0);
        check("sf_err",    res_err,    0);
        tick(); tick(); tick();
        check("sf_hold_valid", res_valid, 1);
        check("sf_hold_count", res_count, 3);
        handshake();
        check("sf_release", res_valid, 0);

        // Parity table: every nibble as a one-beat frame from requester 2
        for (int v = 0; v < 16; v++) begin
            set_req(2, v[3:0], 1'b1);
            tick(); tick(); clr_req(2);
            check("pt_valid",  res_valid,  1);
            check("pt_parity", res_parity, ptab[v]);
            check("pt_count",  res_count,  1);
            check("pt_id",     res_id,     2);
            handshake();
        end

        // Round-robin among 0, 1, 3 with two-beat frames, starting from rr_ptr=0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        res_ready = 1'b1; frames = 0; onehot_bad = 0;
        for (int i = 0; i < NREQ; i++) beatn[i] = 0;
        set_req(0, 4'h1, 1'b0); set_req(1, 4'h1, 1'b0); set_req(3, 4'h1, 1'b0);
        for (int cyc = 0; cyc < 60 && frames < 4; cyc++) begin
            #1;
            rdy = req_ready; vld = req_valid;
            if (!$onehot0(rdy)) onehot_bad++;
            if (res_valid) begin
                check("rr_order",  res_id,     exp_order[frames]);
                check("rr_count",  res_count,  2);
                check("rr_parity", res_parity, 1);
                frames++;
            end
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (rdy[i] && vld[i]) begin
                    if (beatn[i] == 0) begin beatn[i] = 1; set_req(i, 4'h3, 1'b1); end
                    else               begin beatn[i] = 0; set_req(i, 4'h1, 1'b0); end
                end
            end
        end
        clr_req(0); clr_req(1); clr_req(3); res_ready = 1'b0;
        check("rr_frames", frames, 4);
        check("rr_onehot", onehot_bad, 0);

        // Stall: 0x8, five idle cycles, then 0x1 last from requester 1
        tick();
        set_req(1, 4'h8, 1'b0);
        tick(); tick(); clr_req(1);
        for (int k = 0; k < 5; k++) tick();
        set_req(1, 4'h1, 1'b1);
        tick(); clr_req(1);
        check("st_valid",  res_valid,  1);
        check("st_parity", res_parity, 0);
        check("st_count",  res_count,  2);
        check("st_err",    res_err,    0);
        handshake();

        // Timeout: requester 0 sends 0x4 then goes silent
        set_req(0, 4'h4, 1'b0);
        tick(); tick(); clr_req(0);
        for (int k = 0; k < 15; k++) tick();
        check("to_early", res_valid, 0);
        tick();
        check("to_valid",  res_valid,  1);
        check("to_err",    res_err,    1);
        check("to_parity", res_parity, 1);
        check("to_count",  res_count,  1);
        check("to_id",     res_id,     0);

        // Backpressure: result held, no beats accepted while requests wait
        set_req(1, 4'h2, 1'b0); set_req(2, 4'h2, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            snap = {res_valid, res_parity, res_count, res_id, res_err, req_ready};
            check("bp_stable", snap, {1'b1, 1'b1, 8'd1, 2'd0, 1'b1, 4'b0000});
        end
        handshake();
        check("bp_release_valid", res_valid, 0);
        check("bp_release_ready", req_ready, 4'b0000);
        tick();
        check("bp_rr_advance", req_ready, 4'b0010);

        // Reset after two beats of requester 1's frame
        clr_req(2); set_req(1, 4'h1, 1'b0);
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("mr_ready",  req_ready,  0);
        check("mr_valid",  res_valid,  0);
        check("mr_parity", res_parity, 0);
        check("mr_count",  res_count,  0);
        check("mr_err",    res_err,    0);
        clr_req(1);
        set_req(0, 4'hB, 1'b1); set_req(1, 4'h2, 1'b0);
        tick();
        check("mr_rr_zero", req_ready, 4'b0001);
        check("mr_no_res",  res_valid, 0);
        clr_req(1);
        tick(); clr_req(0);
        check("mr_valid2",  res_valid,  1);
        check("mr_parity2", res_parity, 1);
        check("mr_count2",  res_count,  1);
        check("mr_id2",     res_id,     0);
        check("mr_err2",    res_err,    0);
        handshake();

        // Saturation: six beats of 0x1
        set_req(0, 4'h1, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) tick();
        set_req(0, 4'h1, 1'b1);
        tick(); clr_req(0);
        check("sat_valid",  res_valid_s,  1);
        check("sat_count",  res_count_s,  3);
        check("sat_parity", res_parity_s, 0);
        check("wide_count", res_count,    6);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
